// File: rtl/fdiv_seq.sv
// IEEE-754 single/double divider, radix-2 restoring mantissa core, RNE rounding, FTZ.
// Latency: specials out_valid 1 cycle after accept; normal ops MAN_W+5 cycles (28 single, 57 double).
// Backpressure: result held in DONE until out_valid && out_ready; in_ready only in IDLE, no pass-through.
module fdiv_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic [4:0]   flags
);

  localparam int EXP_W = (N == 64) ? 11 : 8;
  localparam int MAN_W = (N == 64) ? 52 : 23;
  localparam int BIAS  = 2**(EXP_W-1) - 1;
  localparam int M     = MAN_W + 1;          // significand width incl. hidden bit
  localparam int Q     = MAN_W + 3;          // quotient bits: integer + MAN_W + guard + round
  localparam int EW2   = EXP_W + 2;          // signed exponent working width
  localparam int CNT_W = $clog2(Q + 1);

  localparam logic signed [EW2-1:0] BIAS_S = EW2'(BIAS);
  localparam logic signed [EW2-1:0] EMAX_S = EW2'(2**EXP_W - 1);
  localparam logic signed [EW2-1:0] ONE_S  = EW2'(1);
  localparam logic signed [EW2-1:0] ZERO_S = EW2'(0);
  localparam logic [N-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    sign_q, sign_d;
  logic signed [EW2-1:0]   exp_q, exp_d;
  logic [M:0]              rem_q, rem_d;
  logic [M-1:0]            div_q, div_d;
  logic [Q-1:0]            quo_q, quo_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [N-1:0]            out_q, out_d;
  logic [4:0]              flags_q, flags_d;
  logic                    out_valid_q, out_valid_d;

  // operand unpack
  logic [EXP_W-1:0]        ea, eb;
  logic [MAN_W-1:0]        fa, fb;
  logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic                    sign_in, is_special;
  logic signed [EW2-1:0]   exp_in;
  logic [N-1:0]            spec_res;
  logic [4:0]              spec_flags;

  // divider step
  logic [M+1:0]            trial;
  logic                    q_bit;
  logic [M:0]              rem_sel;

  // normalise / round
  logic [Q-1:0]            shifted;
  logic [M-1:0]            mant;
  logic                    g_bit, r_bit, s_bit, round_up, carry, inexact;
  logic [M:0]              sum;
  logic [MAN_W-1:0]        frac;
  logic signed [EW2-1:0]   e_norm;
  logic [N-1:0]            norm_res;
  logic [4:0]              norm_flags;

  // Classify incoming operands (subnormals flushed to zero) and resolve special results by priority.
  always_comb begin
    ea      = a[N-2 -: EXP_W];
    eb      = b[N-2 -: EXP_W];
    fa      = a[MAN_W-1:0];
    fb      = b[MAN_W-1:0];
    a_zero  = (ea == '0);
    b_zero  = (eb == '0);
    a_nan   = (&ea) && (|fa);
    b_nan   = (&eb) && (|fb);
    a_inf   = (&ea) && !(|fa);
    b_inf   = (&eb) && !(|fb);
    sign_in = a[N-1] ^ b[N-1];
    exp_in  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S;
    is_special = a_zero || b_zero || (&ea) || (&eb);

    spec_res   = {sign_in, {(N-1){1'b0}}};
    spec_flags = 5'b00000;
    if (a_nan || b_nan) begin
      spec_res   = QNAN;
      spec_flags = 5'b10000;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res   = QNAN;
      spec_flags = 5'b10000;
    end else if (b_zero && !a_inf) begin
      spec_res   = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_flags = 5'b01000;
    end else if (a_inf) begin
      spec_res   = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  // One restoring step: trial subtract, keep or restore, shift remainder left for the next bit.
  always_comb begin
    trial   = {1'b0, rem_q} - {2'b00, div_q};
    q_bit   = ~trial[M+1];
    rem_sel = q_bit ? trial[M:0] : rem_q;
  end

  // Normalise quotient to 1.x, round to nearest even, then apply exponent range limits.
  always_comb begin
    shifted = quo_q[Q-1] ? quo_q : (quo_q << 1);
    mant    = shifted[Q-1:2];
    g_bit   = shifted[1];
    r_bit   = shifted[0];
    s_bit   = |rem_q;
    round_up = g_bit && (r_bit || s_bit || mant[0]);
    sum     = {1'b0, mant} + {{M{1'b0}}, round_up};
    carry   = sum[M];
    // a carry only occurs from all-ones, so the shifted fraction is zero
    frac    = carry ? sum[MAN_W:1] : sum[MAN_W-1:0];
    inexact = g_bit || r_bit || s_bit;
    e_norm  = exp_q;
    if (!quo_q[Q-1]) e_norm = e_norm - ONE_S;
    if (carry)       e_norm = e_norm + ONE_S;

    norm_res   = {sign_q, e_norm[EXP_W-1:0], frac};
    norm_flags = {4'b0000, inexact};
    if (e_norm >= EMAX_S) begin
      norm_res   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      norm_flags = 5'b00101;
    end else if (e_norm <= ZERO_S) begin
      norm_res   = {sign_q, {(N-1){1'b0}}};
      norm_flags = 5'b00011;
    end
  end

  // FSM next-state and datapath register updates.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    rem_d       = rem_q;
    div_d       = div_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    flags_d     = flags_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = sign_in;
          exp_d  = exp_in;
          rem_d  = {1'b0, 1'b1, fa};
          div_d  = {1'b1, fb};
          quo_d  = '0;
          cnt_d  = '0;
          if (is_special) begin
            out_d   = spec_res;
            flags_d = spec_flags;
            state_d = DONE;
          end else begin
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        rem_d = rem_sel << 1;
        quo_d = {quo_q[Q-2:0], q_bit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(Q-1)) state_d = NORM;
      end
      NORM: begin
        out_d   = norm_res;
        flags_d = norm_flags;
        state_d = DONE;
      end
      DONE: begin
        // out_valid rises one cycle after entering DONE and drops on the handshake edge
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; async reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign flags     = flags_q;

endmodule
